// File: rtl/isa_pkg.sv
// Shared MIPS ISA constants and the fetch-unit state encoding.
// The HALT word is the all-zero instruction.
package isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b000010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} fetch_state_e;
endpackage

// File: rtl/instr_mem.sv
// DEPTH x 32 program store: one write port, registered read port.
// The array itself is not reset; only the read register is, so it comes up as 0.
module instr_mem
  import isa_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value until the next read, so the output is stable during stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Loadable instruction source: program store, word-stepping PC and fetch/issue FSM
// presenting one instruction at a time on a valid/ready handshake until HALT is issued.
module instr_fetch_unit #(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = isa_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       issue_count
);
  import isa_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we, mem_re;
  logic [31:0]       rdata;

  instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    mem_re   = 1'b0;
    // Loads only while the store is not being read by a running program.
    mem_we   = load_en && (state_q == IDLE || state_q == HALTED);
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d     = '0;
          cnt_d    = '0;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        mem_re  = 1'b1;
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (valid_q && instr_ready) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          valid_d = 1'b0;
          if (rdata == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instruction = rdata;
  assign instr_valid = valid_q;
  assign pc          = {{(30-ADDR_W){1'b0}}, pc_q, 2'b00};
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign halted      = halted_q;
  assign issue_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit; the expected issue stream is
// derived from a plain array copy of the loaded program walked word by word.
module tb_instr_fetch_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic [15:0] issue_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] prog8 [8] = '{32'h20080004, 32'h2009000F, 32'h200A0014, 32'h20110008,
                             32'hAE280000, 32'hAE290008, 32'hAE2AFFFC, 32'h00000000};

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .busy(busy),
    .halted(halted), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = 6'(addr); load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts the program and follows the model until HALT or max_acc accepts.
  task automatic run(input int max_acc, input int stall_idx, input int stall_len,
                     input bit rnd, input bit noise,
                     output int idx, output int cnt, output bit saw_halt);
    int stalls = 0;
    int cyc = 0;
    bit done = 0;
    bit r, v;
    logic [31:0] w;
    idx = 0; cnt = 0; saw_halt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fetch_busy", {31'b0, busy}, 1);
    chk("fetch_novalid", {31'b0, instr_valid}, 0);
    @(posedge clk); #1;
    chk("first_valid", {31'b0, instr_valid}, 1);
    while (!done && cyc < 1000) begin
      v = instr_valid;
      w = model_mem[idx];
      if (v) begin
        chk("instr", instruction, w);
        chk("pc", pc, 32'(idx * 4));
        chk("count", {16'b0, issue_count}, 32'(cnt));
      end
      r = 1'b1;
      if (rnd) r = ($urandom_range(0, 2) != 0);
      if (v && idx == stall_idx && stalls < stall_len) begin
        r = 1'b0;
        stalls++;
      end
      instr_ready = r;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        load_en = 1'($urandom_range(0, 1));
        load_addr = 6'($urandom);
        load_data = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
      if (v && !r) chk("hold_valid", {31'b0, instr_valid}, 1);
      if (v && r) begin
        cnt++;
        if (w == 32'h0) begin
          saw_halt = 1;
          done = 1;
        end else begin
          idx = (idx + 1) % DEPTH;
        end
        if (cnt == max_acc) done = 1;
      end
    end
    start = 1'b0; load_en = 1'b0; instr_ready = 1'b0;
    chk("run_done", {31'b0, done}, 1);
  endtask

  task automatic check_halted(input int idx, input int cnt);
    chk("halted", {31'b0, halted}, 1);
    chk("halt_novalid", {31'b0, instr_valid}, 0);
    chk("halt_busy", {31'b0, busy}, 0);
    chk("halt_pc", pc, 32'(idx * 4));
    chk("halt_count", {16'b0, issue_count}, 32'(cnt));
  endtask

  initial begin
    int idx, cnt;
    bit h;
    #3;
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_count", {16'b0, issue_count}, 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // 8-word store program, always ready
    for (int i = 0; i < 8; i++) load_word(i, prog8[i]);
    run(0, -1, 0, 0, 0, idx, cnt, h);
    chk("p8_saw_halt", {31'b0, h}, 1);
    check_halted(idx, cnt);
    chk("p8_pc_1c", pc, 32'h1C);
    chk("p8_cnt_8", {16'b0, issue_count}, 8);

    // same program with a 3-cycle stall on word 2, restarted from HALTED
    run(0, 2, 3, 0, 0, idx, cnt, h);
    check_halted(idx, cnt);
    chk("stall_cnt_8", {16'b0, issue_count}, 8);

    // random stalls plus start/load noise while busy; then a clean rerun proves the store is intact
    run(0, -1, 0, 1, 1, idx, cnt, h);
    check_halted(idx, cnt);
    run(0, -1, 0, 1, 0, idx, cnt, h);
    check_halted(idx, cnt);
    chk("noise_cnt_8", {16'b0, issue_count}, 8);

    // 12-word program, then reload word 0 while HALTED and restart
    load_word(0, 32'h20080008);
    for (int i = 1; i < 11; i++) load_word(i, $urandom | 32'h1);
    load_word(11, 32'h0);
    run(0, -1, 0, 1, 0, idx, cnt, h);
    check_halted(idx, cnt);
    chk("p12_cnt", {16'b0, issue_count}, 12);
    load_word(0, 32'h20080004);
    run(1, -1, 0, 0, 0, idx, cnt, h);
    chk("reload_cnt_1", {16'b0, issue_count}, 1);
    chk("reload_pc", pc, 32'h4);
    do_reset();

    // 64 non-halt words: pc wraps, never halts
    for (int i = 0; i < DEPTH; i++) load_word(i, 32'h20080001);
    run(65, -1, 0, 1, 0, idx, cnt, h);
    chk("wrap_halted", {31'b0, halted}, 0);
    chk("wrap_pc", pc, 32'h4);
    chk("wrap_cnt", {16'b0, issue_count}, 65);
    do_reset();

    // reset while stalled in ISSUE at pc 0x0C
    for (int i = 0; i < 8; i++) load_word(i, prog8[i]);
    run(3, -1, 0, 0, 0, idx, cnt, h);
    instr_ready = 1'b0;
    for (int i = 0; i < 5 && !instr_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("stall_at_c_valid", {31'b0, instr_valid}, 1);
    chk("stall_at_c_pc", pc, 32'h0C);
    chk("stall_at_c_instr", instruction, prog8[3]);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, instr_valid}, 0);
    chk("async_pc", pc, 0);
    chk("async_busy", {31'b0, busy}, 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    run(0, -1, 0, 0, 0, idx, cnt, h);
    check_halted(idx, cnt);
    chk("post_rst_cnt", {16'b0, issue_count}, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction source for the single-cycle MIPS `processor`; replaces hand-driven instruction words with a loadable program store.
- Holds a word-addressed instruction memory, a byte-addressed PC and a fetch/issue FSM.
- Presents one 32-bit instruction at a time on a valid/ready handshake.
- Stops after the HALT word (all zeros) has been issued.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the program store (power of two).
- ADDR_W, 6, log2(DEPTH); word-index width.
- HALT_WORD, 32'h0000_0000, encoding that terminates the program.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write enable for the program store.
- load_addr  input  ADDR_W  word index to write.
- load_data  input  32  instruction word to write.
- start  input  1  single-cycle pulse; begins execution from PC 0.
- instruction  output  32  instruction presented to the processor.
- instr_valid  output  1  `instruction` is valid this cycle.
- instr_ready  input  1  processor accepts `instruction` this cycle.
- pc  output  32  byte address of the current/next fetch.
- busy  output  1  FSM is in FETCH or ISSUE.
- halted  output  1  HALT word has been issued.
- issue_count  output  16  instructions accepted since the last start, including HALT.

Behaviour:
- Reset values (asynchronous): state=IDLE, pc=0, instruction=0, instr_valid=0, busy=0, halted=0, issue_count=0.
- Program store is not reset; its contents survive reset.
- Store: synchronous write and synchronous read, one-cycle read latency. Word index = pc[ADDR_W+1:2]. pc[1:0] is always 00.
- load_en is honoured only in IDLE or HALTED; it is ignored in FETCH or ISSUE.
- States:
  - IDLE: start=1 -> pc=0, issue_count=0, halted=0, go FETCH.
  - FETCH: issue the read at pc; next cycle latch the read data into `instruction`, set instr_valid=1, go ISSUE.
  - ISSUE: hold instruction and instr_valid stable while instr_ready=0. On instr_valid&instr_ready: increment issue_count (saturating at 16'hFFFF). Then:
    - if instruction==HALT_WORD: instr_valid=0, halted=1, pc unchanged, go HALTED.
    - otherwise: instr_valid=0, pc=pc+4, go FETCH.
  - HALTED: halted held at 1. start=1 -> same action as in IDLE (restart from 0).
- start is ignored in FETCH and ISSUE.
- Throughput is at most one instruction every 2 cycles. Latency from start to the first instr_valid is 2 cycles.
- Wrap-around: the increment from word DEPTH-1 wraps pc to 0. pc bits above ADDR_W+1 are always 0.
- load_en and start in the same cycle (IDLE or HALTED): the write is performed, and the FETCH read is issued on the following cycle, so it observes the new word.
- Reset asserted mid-ISSUE: instr_valid drops immediately (asynchronous) and the FSM returns to IDLE.
- busy = (state==FETCH) or (state==ISSUE).

Decomposition:
- Shared package `isa_pkg`:
  - opcode/funct constants (ADDI 6'b001000, SW 6'b101011, LW 6'b100011, R-type 6'b000000; ADD 100000, SUB 100010, MUL 000010, SLL 000000);
  - HALT_WORD;
  - FSM state typedef {IDLE, FETCH, ISSUE, HALTED}.
- One sub-module: `instr_mem`, a DEPTH x 32 synchronous-read, single-write-port RAM. The FSM, PC and counter stay in `instr_fetch_unit`.

Test Plan:
- Load the 8-word store program (4 ADDI, 3 SW, HALT: 0x20080004, 0x2009000F, 0x200A0014, 0x20110008, 0xAE280000, 0xAE290008, 0xAE2AFFFC, 0x00000000); start with instr_ready=1 -> words issued in order, pc steps 0..0x1C, halted=1 with pc=0x1C, issue_count=8.
- Same program with instr_ready low for 3 cycles on word 2 -> instruction holds 0x200A0014 with instr_valid=1 throughout the stall; no skipped or duplicated words; issue_count=8.
- Load 12-word program (0x20080008 ... 0x00000000) and run; then reload word 0 with 0x20080004 while HALTED and start again -> first issued word is 0x20080004 and issue_count restarts at 1.
- Fill all 64 words with non-halt 0x20080001 -> after word 63 is accepted pc wraps to 0; halted stays 0; issue_count=65 after 65 accepts.
- Assert reset while ISSUE is stalled at pc=0x0C -> instr_valid=0, pc=0, state IDLE immediately; program store retains its words and a following start re-issues word 0.
- Pulse start and load_en while busy -> no effect on pc, instruction order or store contents.
